// File: rtl/window_3x3_generator.sv
// Streams raster-order pixels through two line buffers and a 3x3 register
// array, emitting one neighbourhood window per accepted interior pixel.
module window_3x3_generator #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_valid,
  input  logic [DATA_W-1:0] input_pixel,
  output logic              output_valid,
  output logic [DATA_W-1:0] output_pixel_1,
  output logic [DATA_W-1:0] output_pixel_2,
  output logic [DATA_W-1:0] output_pixel_3,
  output logic [DATA_W-1:0] output_pixel_4,
  output logic [DATA_W-1:0] output_pixel_5,
  output logic [DATA_W-1:0] output_pixel_6,
  output logic [DATA_W-1:0] output_pixel_7,
  output logic [DATA_W-1:0] output_pixel_8,
  output logic [DATA_W-1:0] output_pixel_9,
  output logic              output_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_W-1:0] win_q [9];
  logic              valid_q, last_q;
  logic              interior, frame_end;

  assign interior  = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign frame_end = (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (input_valid) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Line buffers are plain storage; a pixel arriving with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && input_valid) begin
      lb0_q[col_q] <= input_pixel;
      lb1_q[col_q] <= lb0_q[col_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= input_valid && interior;
      last_q  <= input_valid && interior && frame_end;
      if (input_valid) begin
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1_q[col_q];
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0_q[col_q];
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= input_pixel;
      end
    end
  end

  assign output_valid   = valid_q;
  assign output_last    = last_q;
  assign output_pixel_1 = win_q[0];
  assign output_pixel_2 = win_q[1];
  assign output_pixel_3 = win_q[2];
  assign output_pixel_4 = win_q[3];
  assign output_pixel_5 = win_q[4];
  assign output_pixel_6 = win_q[5];
  assign output_pixel_7 = win_q[6];
  assign output_pixel_8 = win_q[7];
  assign output_pixel_9 = win_q[8];

endmodule

// File: tb/tb_window_3x3_generator.sv
// Directed bench for window_3x3_generator on a 5x4 frame with
// pixel = {row, col}; each scenario task checks its own results.
module tb_window_3x3_generator;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       input_valid = 1'b0;
  logic [7:0] input_pixel = '0;
  logic       output_valid, output_last;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         acc;
    int         r;
    int         c;
    int         f;
    logic       ov;
    logic       ol;
    logic [71:0] win;
  } rec_t;

  rec_t recs[$];

  window_3x3_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .input_valid(input_valid), .input_pixel(input_pixel),
    .output_valid(output_valid),
    .output_pixel_1(p1), .output_pixel_2(p2), .output_pixel_3(p3),
    .output_pixel_4(p4), .output_pixel_5(p5), .output_pixel_6(p6),
    .output_pixel_7(p7), .output_pixel_8(p8), .output_pixel_9(p9),
    .output_last(output_last)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic cycle(input bit v, input logic [7:0] px);
    input_valid = v;
    input_pixel = px;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    logic [3:0] rr, cc;
    rr = r[3:0];
    cc = c[3:0];
    return {rr, cc};
  endfunction

  function automatic void model(input rec_t x, input bit fillMode,
                                output logic ev, output logic el, output logic [71:0] ew);
    ev = x.acc && x.r >= 2 && x.c >= 2;
    el = ev && x.r == H - 1 && x.c == W - 1;
    ew = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        ew = {ew[63:0], fillMode ? ((x.f % 2 == 0) ? 8'hFF : 8'h00) : pix(x.r - 2 + i, x.c - 2 + j)};
  endfunction

  task automatic stream(input int nPix, input int gapPct, input bit fillMode);
    int r, c, f, acc, guard;
    bit v;
    logic [7:0] px;
    rec_t rec;
    recs.delete();
    r = 0; c = 0; f = 0; acc = 0; guard = 0;
    while (acc < nPix && guard < 4000) begin
      v  = (gapPct == 0) || ($urandom_range(99) >= gapPct);
      px = fillMode ? ((f == 0) ? 8'hFF : 8'h00) : pix(r, c);
      cycle(v, px);
      rec.acc = v; rec.r = r; rec.c = c; rec.f = f;
      rec.ov = output_valid; rec.ol = output_last;
      rec.win = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
      recs.push_back(rec);
      if (v) begin
        acc++;
        if (c == W - 1) begin
          c = 0;
          if (r == H - 1) begin r = 0; f++; end
          else r++;
        end else c++;
      end
      guard++;
    end
    input_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 8'h22 + 8'(k));
      checks++;
      if (output_valid !== 1'b0 || output_last !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset.flags got valid=%b last=%b exp 0 0", output_valid, output_last);
      end
      checks++;
      if ({p1, p2, p3, p4, p5, p6, p7, p8, p9} !== 72'h0) begin
        errors++;
        $display("[TB] FAIL reset.pixels got %h exp 0", {p1, p2, p3, p4, p5, p6, p7, p8, p9});
      end
    end
    rst = 1'b0;
    input_valid = 1'b0;
  endtask

  task automatic test_frame();
    logic ev, el;
    logic [71:0] ew;
    int nWin = 0, nLast = 0;
    logic [71:0] firstWin = 'x, lastWin = 'x;
    stream(20, 0, 1'b0);
    foreach (recs[i]) begin
      model(recs[i], 1'b0, ev, el, ew);
      checks++;
      if (recs[i].ov !== ev || recs[i].ol !== el) begin
        errors++;
        $display("[TB] FAIL frame.flags at r%0d c%0d got %b%b exp %b%b", recs[i].r, recs[i].c, recs[i].ov, recs[i].ol, ev, el);
      end
      if (ev) begin
        checks++;
        if (recs[i].win !== ew) begin
          errors++;
          $display("[TB] FAIL frame.window at r%0d c%0d got %h exp %h", recs[i].r, recs[i].c, recs[i].win, ew);
        end
        if (nWin == 0) firstWin = recs[i].win;
        lastWin = recs[i].win;
      end
      if (recs[i].ov === 1'b1) nWin++;
      if (recs[i].ol === 1'b1) nLast++;
    end
    checks++;
    if (nWin != 6 || nLast != 1) begin
      errors++;
      $display("[TB] FAIL frame.count got %0d/%0d exp 6/1", nWin, nLast);
    end
    checks++;
    if (firstWin !== 72'h00_01_02_10_11_12_20_21_22) begin
      errors++;
      $display("[TB] FAIL frame.first got %h exp 000102101112202122", firstWin);
    end
    checks++;
    if (lastWin !== 72'h12_13_14_22_23_24_32_33_34) begin
      errors++;
      $display("[TB] FAIL frame.last got %h exp 121314222324323334", lastWin);
    end
  endtask

  task automatic test_gaps();
    logic ev, el;
    logic [71:0] ew;
    int nWin = 0;
    stream(20, 50, 1'b0);
    foreach (recs[i]) begin
      model(recs[i], 1'b0, ev, el, ew);
      checks++;
      if (recs[i].ov !== ev || recs[i].ol !== el) begin
        errors++;
        $display("[TB] FAIL gaps.flags at r%0d c%0d acc=%0d got %b%b exp %b%b", recs[i].r, recs[i].c, recs[i].acc, recs[i].ov, recs[i].ol, ev, el);
      end
      if (ev) begin
        checks++;
        if (recs[i].win !== ew) begin
          errors++;
          $display("[TB] FAIL gaps.window at r%0d c%0d got %h exp %h", recs[i].r, recs[i].c, recs[i].win, ew);
        end
      end
      if (!recs[i].acc && i > 0) begin
        checks++;
        if (recs[i].win !== recs[i-1].win) begin
          errors++;
          $display("[TB] FAIL gaps.hold got %h exp %h", recs[i].win, recs[i-1].win);
        end
      end
      if (recs[i].ov === 1'b1) nWin++;
    end
    checks++;
    if (nWin != 6) begin
      errors++;
      $display("[TB] FAIL gaps.count got %0d exp 6", nWin);
    end
  endtask

  task automatic test_back_to_back();
    logic ev, el;
    logic [71:0] ew;
    int nWin = 0, nLast = 0;
    stream(40, 0, 1'b0);
    foreach (recs[i]) begin
      model(recs[i], 1'b0, ev, el, ew);
      checks++;
      if (recs[i].ov !== ev || recs[i].ol !== el) begin
        errors++;
        $display("[TB] FAIL b2b.flags at f%0d r%0d c%0d got %b%b exp %b%b", recs[i].f, recs[i].r, recs[i].c, recs[i].ov, recs[i].ol, ev, el);
      end
      if (ev) begin
        checks++;
        if (recs[i].win !== ew) begin
          errors++;
          $display("[TB] FAIL b2b.window at f%0d r%0d c%0d got %h exp %h", recs[i].f, recs[i].r, recs[i].c, recs[i].win, ew);
        end
      end
      if (recs[i].ov === 1'b1) nWin++;
      if (recs[i].ol === 1'b1) nLast++;
    end
    checks++;
    if (nWin != 12 || nLast != 2) begin
      errors++;
      $display("[TB] FAIL b2b.count got %0d/%0d exp 12/2", nWin, nLast);
    end
  endtask

  task automatic test_mid_reset();
    logic ev, el;
    logic [71:0] ew;
    int nWin = 0;
    stream(12, 0, 1'b0);
    foreach (recs[i]) begin
      checks++;
      if (recs[i].ov !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst.pre at r%0d c%0d got %b exp 0", recs[i].r, recs[i].c, recs[i].ov);
      end
    end
    rst = 1'b1;
    cycle(1'b1, 8'h22);
    rst = 1'b0;
    input_valid = 1'b0;
    checks++;
    if (output_valid !== 1'b0 || {p1, p5, p9} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL midrst.reset got valid=%b pix=%h exp 0 000000", output_valid, {p1, p5, p9});
    end
    stream(20, 0, 1'b0);
    foreach (recs[i]) begin
      model(recs[i], 1'b0, ev, el, ew);
      checks++;
      if (recs[i].ov !== ev || recs[i].ol !== el) begin
        errors++;
        $display("[TB] FAIL midrst.flags at r%0d c%0d got %b%b exp %b%b", recs[i].r, recs[i].c, recs[i].ov, recs[i].ol, ev, el);
      end
      if (ev) begin
        checks++;
        if (recs[i].win !== ew) begin
          errors++;
          $display("[TB] FAIL midrst.window at r%0d c%0d got %h exp %h", recs[i].r, recs[i].c, recs[i].win, ew);
        end
      end
      if (recs[i].ov === 1'b1) nWin++;
    end
    checks++;
    if (nWin != 6) begin
      errors++;
      $display("[TB] FAIL midrst.count got %0d exp 6", nWin);
    end
  endtask

  task automatic test_fill();
    logic ev, el;
    logic [71:0] ew;
    int nWin = 0;
    stream(40, 0, 1'b1);
    foreach (recs[i]) begin
      model(recs[i], 1'b1, ev, el, ew);
      checks++;
      if (recs[i].ov !== ev) begin
        errors++;
        $display("[TB] FAIL fill.valid at f%0d r%0d c%0d got %b exp %b", recs[i].f, recs[i].r, recs[i].c, recs[i].ov, ev);
      end
      if (ev) begin
        checks++;
        if (recs[i].win !== ew) begin
          errors++;
          $display("[TB] FAIL fill.window at f%0d r%0d c%0d got %h exp %h", recs[i].f, recs[i].r, recs[i].c, recs[i].win, ew);
        end
      end
      if (recs[i].ov === 1'b1) nWin++;
    end
    checks++;
    if (nWin != 12) begin
      errors++;
      $display("[TB] FAIL fill.count got %0d exp 12", nWin);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
